// File: rtl/wb_alu_pkg.sv
// Shared definitions for the wb_alu_seq ALU peripheral: opcodes, register word
// offsets, STATUS bit positions and the command FSM encoding.
package wb_alu_pkg;

    localparam logic [3:0] OP_NOT  = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_PASS = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_DEC  = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_INC  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_DIV  = 4'd9;
    localparam logic [3:0] OP_SHL  = 4'd10;
    localparam logic [3:0] OP_SHR  = 4'd11;
    localparam logic [3:0] OP_XOR  = 4'd12;

    // Register word offsets (byte offset / 4) within the window.
    localparam logic [2:0] IDX_OPA    = 3'd0;
    localparam logic [2:0] IDX_OPB    = 3'd1;
    localparam logic [2:0] IDX_CTRL   = 3'd2;
    localparam logic [2:0] IDX_STATUS = 3'd3;
    localparam logic [2:0] IDX_RES_LO = 3'd4;
    localparam logic [2:0] IDX_RES_HI = 3'd5;
    localparam logic [2:0] IDX_BUTTON = 3'd6;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_CARRY   = 2;
    localparam int ST_ZERO    = 3;
    localparam int ST_DIV0    = 4;
    localparam int ST_OVERRUN = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [6:0] sat_shamt(input logic [5:0] b, input int w2);
        sat_shamt = ({1'b0, b} > 7'(w2)) ? 7'(w2) : {1'b0, b};
    endfunction

endpackage

// File: rtl/wb_alu_seq_muldiv.sv
// seq_muldiv: iterative unsigned shift-add multiply / restoring divide, one bit
// per cycle for W cycles. o_lo/o_hi carry the final value during the o_done cycle.
module seq_muldiv #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_start,
    input  logic         i_is_div,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_lo,
    output logic [W-1:0] o_hi,
    output logic         o_div0
);

    logic [W-1:0] r_lo, r_hi, r_b;
    logic [5:0]   r_cnt;
    logic         r_div, r_busy;
    logic [W:0]   w_sum, w_shift;
    logic [W+1:0] w_diff;
    logic         w_neg;
    logic [W-1:0] w_lo_nxt, w_hi_nxt;
    logic         w_unused;

    assign o_div0   = i_is_div && (i_b == {W{1'b0}});
    assign o_done   = r_busy && (r_cnt == 6'd1);
    assign o_busy   = r_busy;
    assign o_lo     = w_lo_nxt;
    assign o_hi     = w_hi_nxt;
    assign w_unused = w_diff[W];

    // One iteration step: hi holds partial product / remainder, lo the multiplier / quotient.
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(W+1){1'b0}});
        w_shift = {r_hi, r_lo[W-1]};
        w_diff  = {1'b0, w_shift} - {2'b00, r_b};
        w_neg   = w_diff[W+1];
        if (r_div) begin
            w_hi_nxt = w_neg ? w_shift[W-1:0] : w_diff[W-1:0];
            w_lo_nxt = {r_lo[W-2:0], ~w_neg};
        end else begin
            w_hi_nxt = w_sum[W:1];
            w_lo_nxt = {w_sum[0], r_lo[W-1:1]};
        end
    end

    // Operand load and iteration counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lo   <= {W{1'b0}};
            r_hi   <= {W{1'b0}};
            r_b    <= {W{1'b0}};
            r_cnt  <= 6'd0;
            r_div  <= 1'b0;
            r_busy <= 1'b0;
        end else if (i_start && !o_div0) begin
            r_lo   <= i_a;
            r_hi   <= {W{1'b0}};
            r_b    <= i_b;
            r_cnt  <= 6'(W);
            r_div  <= i_is_div;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_lo  <= w_lo_nxt;
            r_hi  <= w_hi_nxt;
            r_cnt <= r_cnt - 6'd1;
            if (r_cnt == 6'd1) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/wb_alu_seq.sv
// wb_alu_seq: Wishbone ALU peripheral with start/busy/done FSM and multi-cycle MUL/DIV.
// Optional macro WB_ALU_IRQ_EN adds o_irq = done & CTRL[16].
module wb_alu_seq
    import wb_alu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          DATA_W       = 32,
    parameter int          N_LEDS       = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [31:0]       i_wb_addr,
    input  logic [31:0]       i_wb_data,
    output logic              o_wb_ack,
    output logic              o_wb_stall,
    output logic [31:0]       o_wb_data,
    input  logic              buttons,
    output logic [N_LEDS-1:0] led_enb,
`ifdef WB_ALU_IRQ_EN
    output logic              o_irq,
`endif
    output logic [N_LEDS-1:0] leds
);

    localparam int W = DATA_W;

    state_t          r_state, w_state_nxt;
    logic [W-1:0]    r_opa, r_opb, r_sa, r_sb, r_res_lo, r_res_hi;
    logic [3:0]      r_op;
    logic            r_done, r_carry, r_zero, r_div0, r_ovr, r_ack;
    logic [31:0]     r_rdata, w_rdata, w_off;
    logic [N_LEDS-1:0] r_leds;
    logic [2:0]      w_idx;
    logic            w_req, w_wr, w_busy, w_start, w_start_ok, w_clr_done, w_done_nxt;
    logic            w_is_md, w_md_go, w_md_busy, w_md_done, w_md_div0, w_unused;
    logic [W-1:0]    w_md_lo, w_md_hi, w_res_lo, w_res_hi;
    logic [2*W-1:0]  w_alu;
    logic [W:0]      w_sum1;
    logic [6:0]      w_sh;
    logic            w_alu_c, w_fin, w_carry, w_div0;
    logic [N_LEDS+W+5:0] w_led_src;
    logic            w_irq_mask;

    assign w_off      = i_wb_addr - BASE_ADDRESS;
    assign w_req      = i_wb_cyc && i_wb_stb && (w_off < 32'd28);
    assign w_idx      = w_off[4:2];
    assign w_wr       = w_req && i_wb_we;
    assign w_busy     = (r_state == S_EXEC) || (r_state == S_RUN);
    assign w_start    = w_wr && (w_idx == IDX_CTRL) && i_wb_data[8];
    assign w_start_ok = w_start && !w_busy;
    assign w_clr_done = w_wr && (w_idx == IDX_STATUS) && i_wb_data[ST_DONE];
    assign w_is_md    = (r_op == OP_MUL) || (r_op == OP_DIV);
    assign w_md_go    = (r_state == S_EXEC) && w_is_md && !w_md_div0;
    assign w_unused   = w_md_busy;

    seq_muldiv #(.W(W)) u_muldiv (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_start  (w_md_go),
        .i_is_div (r_op == OP_DIV),
        .i_a      (r_sa),
        .i_b      (r_sb),
        .o_busy   (w_md_busy),
        .o_done   (w_md_done),
        .o_lo     (w_md_lo),
        .o_hi     (w_md_hi),
        .o_div0   (w_md_div0)
    );

    // Command FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Command FSM next state; DONE accepts a new start exactly like IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) w_state_nxt = S_EXEC;
                else            w_state_nxt = r_state;
            end
            S_EXEC: begin
                if (w_md_go) w_state_nxt = S_RUN;
                else         w_state_nxt = S_DONE;
            end
            S_RUN: begin
                if (w_md_done) w_state_nxt = S_DONE;
                else           w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Single-cycle ALU on the snapshotted operands, 2W-bit result.
    always_comb begin
        w_alu   = {(2*W){1'b0}};
        w_alu_c = 1'b0;
        w_sum1  = {(W+1){1'b0}};
        w_sh    = sat_shamt(r_sb[5:0], 2*W);
        case (r_op)
            OP_NOT:  w_alu = {{W{1'b0}}, ~r_sa};
            OP_AND:  w_alu = {{W{1'b0}}, r_sa & r_sb};
            OP_PASS: w_alu = {{W{1'b0}}, r_sa};
            OP_OR:   w_alu = {{W{1'b0}}, r_sa | r_sb};
            OP_XOR:  w_alu = {{W{1'b0}}, r_sa ^ r_sb};
            OP_DEC:  w_sum1 = {1'b0, r_sa} - {{W{1'b0}}, 1'b1};
            OP_ADD:  w_sum1 = {1'b0, r_sa} + {1'b0, r_sb};
            OP_SUB:  w_sum1 = {1'b0, r_sa} - {1'b0, r_sb};
            OP_INC:  w_sum1 = {1'b0, r_sa} + {{W{1'b0}}, 1'b1};
            OP_SHL:  w_alu = {{W{1'b0}}, r_sa} << w_sh;
            OP_SHR:  w_alu = {{W{1'b0}}, r_sa} >> w_sh;
            default: w_alu = {(2*W){1'b0}};
        endcase
        if ((r_op >= OP_DEC) && (r_op <= OP_INC)) begin
            w_alu   = {{W{1'b0}}, w_sum1[W-1:0]};
            w_alu_c = w_sum1[W];
        end else begin
            w_alu_c = 1'b0;
        end
    end

    // Pick the value finishing this cycle: single-cycle op, div-by-zero, or MUL/DIV.
    always_comb begin
        w_fin    = 1'b0;
        w_res_lo = w_alu[W-1:0];
        w_res_hi = w_alu[2*W-1:W];
        w_carry  = w_alu_c;
        w_div0   = 1'b0;
        if ((r_state == S_EXEC) && !w_md_go) begin
            w_fin = 1'b1;
            if (w_md_div0) begin
                w_res_lo = {W{1'b1}};
                w_res_hi = r_sa;
                w_carry  = 1'b0;
                w_div0   = 1'b1;
            end else begin
                w_div0 = 1'b0;
            end
        end else if ((r_state == S_RUN) && w_md_done) begin
            w_fin    = 1'b1;
            w_res_lo = w_md_lo;
            w_res_hi = w_md_hi;
            w_carry  = 1'b0;
        end else begin
            w_fin = 1'b0;
        end
        if (w_fin)           w_done_nxt = 1'b1;
        else if (w_start_ok) w_done_nxt = 1'b0;
        else if (w_clr_done) w_done_nxt = 1'b0;
        else                 w_done_nxt = r_done;
    end

    // Operand/opcode registers, snapshot, result and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_opa <= {W{1'b0}}; r_opb <= {W{1'b0}};
            r_sa <= {W{1'b0}};  r_sb <= {W{1'b0}};
            r_res_lo <= {W{1'b0}}; r_res_hi <= {W{1'b0}};
            r_op <= 4'd0; r_done <= 1'b0; r_carry <= 1'b0;
            r_zero <= 1'b0; r_div0 <= 1'b0; r_ovr <= 1'b0;
        end else begin
            if (w_wr && !w_busy && (w_idx == IDX_OPA))  r_opa <= i_wb_data[W-1:0];
            if (w_wr && !w_busy && (w_idx == IDX_OPB))  r_opb <= i_wb_data[W-1:0];
            if (w_wr && !w_busy && (w_idx == IDX_CTRL)) r_op  <= i_wb_data[3:0];
            if (w_start_ok) begin
                r_sa <= r_opa;
                r_sb <= r_opb;
            end
            if (w_fin) begin
                r_res_lo <= w_res_lo;
                r_res_hi <= w_res_hi;
                r_carry  <= w_carry;
                r_zero   <= ({w_res_hi, w_res_lo} == {(2*W){1'b0}});
                r_div0   <= w_div0;
            end
            r_done <= w_done_nxt;
            if (w_start && w_busy) r_ovr <= 1'b1;
            else if (w_wr && (w_idx == IDX_STATUS) && i_wb_data[ST_OVERRUN]) r_ovr <= 1'b0;
        end
    end

`ifdef WB_ALU_IRQ_EN
    logic r_irq_mask, r_irq;
    assign w_irq_mask = r_irq_mask;
    assign o_irq      = r_irq;

    // Interrupt mask (CTRL[16]) and registered done-level interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask <= 1'b0;
            r_irq      <= 1'b0;
        end else if (w_wr && (w_idx == IDX_CTRL)) begin
            r_irq_mask <= i_wb_data[16];
            r_irq      <= w_done_nxt & i_wb_data[16];
        end else begin
            r_irq <= w_done_nxt & r_irq_mask;
        end
    end
`else
    assign w_irq_mask = 1'b0;
`endif

    // Read data mux; narrow registers are zero-extended.
    always_comb begin
        w_rdata = 32'd0;
        case (w_idx)
            IDX_OPA:    w_rdata = 32'(r_opa);
            IDX_OPB:    w_rdata = 32'(r_opb);
            IDX_CTRL:   w_rdata = {15'd0, w_irq_mask, 12'd0, r_op};
            IDX_STATUS: w_rdata = {26'd0, r_ovr, r_div0, r_zero, r_carry, r_done, w_busy};
            IDX_RES_LO: w_rdata = 32'(r_res_lo);
            IDX_RES_HI: w_rdata = 32'(r_res_hi);
            IDX_BUTTON: w_rdata = {31'd0, buttons};
            default:    w_rdata = 32'd0;
        endcase
    end

    // Bus acknowledge and read data, one cycle after a mapped request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ack   <= w_req;
            r_rdata <= (w_req && !i_wb_we) ? w_rdata : 32'd0;
        end
    end

    assign w_led_src = {{N_LEDS{1'b0}}, r_res_lo, r_done, w_busy, r_op};

    // Debug display refresh.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_leds <= {N_LEDS{1'b0}};
        else          r_leds <= w_led_src[N_LEDS-1:0];
    end

    assign o_wb_ack   = r_ack;
    assign o_wb_data  = r_rdata;
    assign o_wb_stall = 1'b0;
    assign led_enb    = {N_LEDS{1'b0}};
    assign leds       = r_leds;

endmodule

// File: tb/tb_wb_alu_seq.sv
// Directed, table-driven bench for wb_alu_seq (default parameters).
module tb_wb_alu_seq;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] O_OPA = 32'd0, O_OPB = 32'd4, O_CTRL = 32'd8, O_ST = 32'd12;
    localparam logic [31:0] O_LO = 32'd16, O_HI = 32'd20, O_BTN = 32'd24;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, buttons = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        ack, stall;
    logic [31:0] rdata;
    logic [11:0] led_enb, leds;
`ifdef WB_ALU_IRQ_EN
    logic        irq;
`endif
    int total = 0;
    int bad = 0;

    wb_alu_seq dut (
        .clk(clk), .reset_n(reset_n),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata),
        .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_data(rdata),
        .buttons(buttons), .led_enb(led_enb),
`ifdef WB_ALU_IRQ_EN
        .o_irq(irq),
`endif
        .leds(leds)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] off, input logic [31:0] d,
                        output logic a, output logic [31:0] q);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; addr = BASE + off; wdata = d;
        @(posedge clk);
        #1;
        a = ack;
        q = rdata;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        logic a;
        logic [31:0] q;
        xfer(1'b1, off, d, a, q);
        chk("wr_ack", {31'd0, a}, 32'd1);
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] q);
        logic a;
        xfer(1'b0, off, 32'd0, a, q);
        chk("rd_ack", {31'd0, a}, 32'd1);
    endtask

    // Poll STATUS; n = number of polls that saw busy (first poll is the cycle after start).
    task automatic wait_done(output int n);
        logic [31:0] s;
        n = 0;
        s = 32'd1;
        for (int i = 0; i < 200; i++) begin
            rd(O_ST, s);
            if (!s[0]) break;
            n++;
        end
        chk("busy_timeout", {31'd0, s[0]}, 32'd0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, lo, hi;
        logic [5:0]  st;
        int          cyc;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] q;
        int n;
        vecs.push_back('{4'd5,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 6'h0E, 1});
        vecs.push_back('{4'd8,  32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080, 32'h0B00_EA4E, 6'h02, 33});
        vecs.push_back('{4'd9,  32'd100,       32'd7,         32'd14,        32'd2,        6'h02, 33});
        vecs.push_back('{4'd9,  32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,        6'h12, 1});
        vecs.push_back('{4'd0,  32'h0F0F_0F0F, 32'h0,         32'hF0F0_F0F0, 32'h0,        6'h02, 1});
        vecs.push_back('{4'd1,  32'hA5A5_A5A5, 32'h0FF0_0FF0, 32'h05A0_05A0, 32'h0,        6'h02, 1});
        vecs.push_back('{4'd2,  32'h0,         32'h1234,      32'h0,         32'h0,        6'h0A, 1});
        vecs.push_back('{4'd3,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 32'h0,        6'h02, 1});
        vecs.push_back('{4'd4,  32'h0,         32'h0,         32'hFFFF_FFFF, 32'h0,        6'h06, 1});
        vecs.push_back('{4'd6,  32'd3,         32'd5,         32'hFFFF_FFFE, 32'h0,        6'h06, 1});
        vecs.push_back('{4'd6,  32'd5,         32'd3,         32'd2,         32'h0,        6'h02, 1});
        vecs.push_back('{4'd7,  32'hFFFF_FFFF, 32'h0,         32'h0,         32'h0,        6'h0E, 1});
        vecs.push_back('{4'd5,  32'd1,         32'd2,         32'd3,         32'h0,        6'h02, 1});
        vecs.push_back('{4'd10, 32'h8000_0001, 32'd4,         32'h0000_0010, 32'h8,        6'h02, 1});
        vecs.push_back('{4'd10, 32'd1,         32'h7F,        32'h0,         32'h8000_0000, 6'h02, 1});
        vecs.push_back('{4'd11, 32'h8000_0000, 32'd31,        32'd1,         32'h0,        6'h02, 1});
        vecs.push_back('{4'd11, 32'h8000_0000, 32'd40,        32'h0,         32'h0,        6'h0A, 1});
        vecs.push_back('{4'd12, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 32'h0,        6'h02, 1});
        vecs.push_back('{4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0,        6'h0A, 1});
        vecs.push_back('{4'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 6'h02, 33});
        vecs.push_back('{4'd9,  32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 32'hF,        6'h02, 33});

        // Outputs while held in reset.
        #3;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_data", rdata, 32'd0);
        chk("rst_leds", {20'd0, leds}, 32'd0);
        chk("stall", {31'd0, stall}, 32'd0);
        chk("led_enb", {20'd0, led_enb}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        buttons = 1'b1;
        rd(O_BTN, q);
        chk("button", q, 32'h1);

        // Reset asserted in the middle of a MUL aborts it.
        wr(O_OPA, 32'h1234_5678);
        wr(O_OPB, 32'h9ABC_DEF0);
        wr(O_CTRL, 32'h108);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_leds", {20'd0, leds}, 32'd0);
        chk("midrst_ack", {31'd0, ack}, 32'd0);
        chk("midrst_data", rdata, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd(O_ST, q);  chk("midrst_status", q, 32'd0);
        rd(O_LO, q);  chk("midrst_lo", q, 32'd0);
        rd(O_HI, q);  chk("midrst_hi", q, 32'd0);
        rd(O_OPA, q); chk("midrst_opa", q, 32'd0);

        // Table of operations.
        foreach (vecs[i]) begin
            wr(O_OPA, vecs[i].a);
            wr(O_OPB, vecs[i].b);
            wr(O_CTRL, {23'd0, 1'b1, 4'd0, vecs[i].op});
            wait_done(n);
            chk($sformatf("v%0d_cycles", i), n, vecs[i].cyc);
            rd(O_LO, q); chk($sformatf("v%0d_lo", i), q, vecs[i].lo);
            rd(O_HI, q); chk($sformatf("v%0d_hi", i), q, vecs[i].hi);
            rd(O_ST, q); chk($sformatf("v%0d_status", i), q, {26'd0, vecs[i].st});
        end

        // Overrun and dropped operand write while MUL is busy.
        wr(O_OPA, 32'h1234_5678);
        wr(O_OPB, 32'h9ABC_DEF0);
        wr(O_CTRL, 32'h108);
        wr(O_OPA, 32'd3);
        wr(O_CTRL, 32'h105);
        wait_done(n);
        rd(O_ST, q);   chk("ovr_status", q, 32'h22);
        rd(O_OPA, q);  chk("ovr_opa", q, 32'h1234_5678);
        rd(O_LO, q);   chk("ovr_lo", q, 32'h242D_2080);
        rd(O_HI, q);   chk("ovr_hi", q, 32'h0B00_EA4E);
        rd(O_CTRL, q); chk("ovr_ctrl", q, 32'h8);
        wr(O_ST, 32'h20);
        rd(O_ST, q);   chk("w1c_ovr", q, 32'h02);
        wr(O_ST, 32'h02);
        rd(O_ST, q);   chk("w1c_done", q, 32'h00);

        // Read-only register write is ignored.
        wr(O_LO, 32'hDEAD_BEEF);
        rd(O_LO, q);   chk("ro_lo", q, 32'h242D_2080);

        // Unmapped addresses get no ack.
        begin
            logic a;
            xfer(1'b0, 32'd28, 32'd0, a, q);
            chk("unmapped_ack", {31'd0, a}, 32'd0);
            @(posedge clk);
            #1;
            chk("unmapped_ack2", {31'd0, ack}, 32'd0);
            xfer(1'b1, 32'hFFFF_FFFC, 32'd1, a, q);
            chk("below_base_ack", {31'd0, a}, 32'd0);
        end

        // LED display: {RES_LO[5:0], done, busy, opcode}.
        wr(O_OPA, 32'h2A);
        wr(O_OPB, 32'h15);
        wr(O_CTRL, 32'h103);
        wait_done(n);
        @(posedge clk);
        #1;
        chk("leds", {20'd0, leds}, 32'hFE3);

`ifdef WB_ALU_IRQ_EN
        wr(O_CTRL, 32'h1_0102);
        wait_done(n);
        chk("irq_set", {31'd0, irq}, 32'd1);
        rd(O_CTRL, q); chk("irq_mask_rd", q, 32'h1_0002);
        wr(O_ST, 32'h02);
        chk("irq_clr", {31'd0, irq}, 32'd0);
`else
        wr(O_CTRL, 32'h1_0002);
        rd(O_CTRL, q); chk("ctrl16_ignored", q, 32'h2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_alu_seq.md
Name: wb_alu_seq

Overview:
- Wishbone-mapped, parametrised ALU peripheral for the user project area; next generation of the single-register ALU block.
- Adds a start/busy/done command FSM, multi-cycle unsigned multiply and divide, status flags (carry, zero, div0, overrun) and configurable operand width.
- Exposes the same LED debug output style as the current ALU block.
- Sits on the Caravel Wishbone bus behind BASE_ADDRESS.

Parameters:
- BASE_ADDRESS, 32'h3000_0000, base of the 7-word register window.
- DATA_W, 32, operand width, legal range 8..32. Bus values are truncated on write and zero-extended on read.
- N_LEDS, 12, LED output width, minimum 6.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- i_wb_cyc  in  1  bus cycle.
- i_wb_stb  in  1  strobe.
- i_wb_we  in  1  write enable.
- i_wb_addr  in  32  byte address.
- i_wb_data  in  32  write data.
- o_wb_ack  out  1  registered acknowledge.
- o_wb_stall  out  1  tied 0.
- o_wb_data  out  32  registered read data.
- buttons  in  1  raw button input, readable.
- led_enb  out  N_LEDS  output enables, tied all-zero (outputs driven).
- leds  out  N_LEDS  debug display.

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low on reset_n. While reset_n is low, all registers and outputs are 0 and the FSM is IDLE. Assertion during an operation aborts it; no partial result is kept.
- Register map (offsets from BASE_ADDRESS):
  - +0 OPA (RW).
  - +4 OPB (RW).
  - +8 CTRL (W): [3:0] opcode, [8] start. Read returns the last opcode.
  - +12 STATUS: [0] busy, [1] done, [2] carry, [3] zero, [4] div0, [5] overrun. Writing 1 to [1] or [5] clears that bit.
  - +16 RES_LO (R).
  - +20 RES_HI (R).
  - +24 BUTTON (R): {31'b0, buttons}.
- Bus timing:
  - A request is stb&cyc to a mapped address. It is acked exactly 1 cycle later; data is valid with the ack.
  - Back-to-back requests get one ack per request cycle.
  - Unmapped addresses are never acked.
  - Writes to RO registers are acked and ignored.
- Writes to OPA or OPB while busy are acked and dropped.
- Opcodes (A=OPA, B=OPB, W=DATA_W):
  - 0 ~A; 1 A&B; 2 A; 3 A|B; 4 A-1; 5 A+B; 6 A-B; 7 A+1.
  - 8 MUL, unsigned, 2W-bit result.
  - 9 DIV, unsigned: LO=quotient, HI=remainder.
  - 10 A<<B, 11 A>>B: 2W-bit, shift amount B[5:0] saturated at 2W.
  - 12 A^B.
  - 13-15: result 0.
- FSM states: IDLE, EXEC, RUN, DONE.
  - Start write accepted at edge E0: A, B and op are snapshotted and state goes to EXEC.
  - Single-cycle ops: result registered at E1, done=1, busy=0, state DONE.
  - MUL/DIV: EXEC loads at E1, then RUN does W shift-add or restoring-subtract iterations. Result and done at E(W+1).
  - DONE behaves as IDLE for a new start. A new start clears done at acceptance.
- busy=1 from E0+1 until the result edge.
- A start while busy is ignored and sets overrun (sticky).
- Flags (updated with the result):
  - zero = (full result == 0).
  - carry = carry-out for 5 and 7; borrow for 4 and 6; else 0.
- Results narrower than 2W: HI=0.
- DIV with B=0: completes at E1 with LO=all-ones(W), HI=A, div0=1.
- Overflow wraps modulo 2^W in LO. Carry captures bit W for ADD/INC.
- leds:
  - [3:0] opcode.
  - [4] busy.
  - [5] done.
  - [N_LEDS-1:6] RES_LO low bits.
  - Registered each cycle.

Optional Feature:
- WB_ALU_IRQ_EN defined: adds output o_irq (1 bit, reset 0).
  - o_irq is a level = done & irq_mask, where irq_mask is CTRL[16] (RW).
  - Clearing done deasserts o_irq on the next edge.
- Undefined: no o_irq port. CTRL[16] reads 0 and writes are ignored.

Decomposition:
- Package wb_alu_pkg: opcode localparams (OP_NOT..OP_XOR), register offset localparams, STATUS bit indices, FSM state encoding.
- One sub-module, seq_muldiv: iterative unsigned multiply/divide with W-cycle handshake.
  - Inputs: start, is_div, a, b.
  - Outputs: busy, done pulse, lo, hi, div0.

Test Plan:
- Reset/ID: assert reset_n=0 mid-MUL → all STATUS=0, RES=0, leds=0. Read BUTTON with buttons=1 → 0x00000001, ack 1 cycle after stb.
- ADD carry: OPA=0xFFFFFFFF, OPB=1, op5+start → at E1 RES_LO=0, RES_HI=0, carry=1, zero=1, done=1.
- MUL latency: OPA=0x12345678, OPB=0x9ABCDEF0, op8 → busy for 33 cycles; RES_HI=0x0B00EA4E, RES_LO=0x242D2080.
- DIV and div0: 100/7 → LO=14, HI=2 after 33 cycles. 5/0 → LO=0xFFFFFFFF, HI=5, div0=1 at E1.
- Overrun/drop: start MUL, then while busy write OPA=3 and start op5 → overrun=1, OPA unchanged, MUL result intact. W1C clears overrun.
- Unmapped/IRQ: read BASE+28 → no ack. With WB_ALU_IRQ_EN and CTRL[16]=1, op2 → o_irq=1; write STATUS[1]=1 → o_irq=0 next cycle.
